// File: rtl/tx_pkg.sv
// Shared types for the frame serializer.
//   byte_t          - one byte on the downstream link
//   state_t         - serializer FSM states
//   bytes_per_elem  - number of bytes in one WIDTH-bit element
package tx_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2,
        ST_CSUM = 2'd3
    } state_t;

    function automatic int bytes_per_elem(input int width);
        return width / 8;
    endfunction

endpackage

// File: rtl/tx_seq_fifo.sv
// Circular store of whole sequences for the serializer.
//   clk, rst_n  - clock, async active-low reset (storage array is not reset)
//   push_req    - a sequence is offered on data_in; taken only when not full
//   data_in     - DEPTH x WIDTH sequence to store
//   pop         - current sequence has been fully sent; free its slot
//   full/empty  - count == NUM_SEQ / count == 0
//   count       - number of stored sequences
//   overflow    - sticky: a push was offered while full
//   rd_seq      - read port; shows the head slot, or the slot after it while
//                 pop is high so the next sequence can start on the same edge
module tx_seq_fifo
    import tx_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 8,
    parameter int NUM_SEQ = 10
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             push_req,
    input  logic [WIDTH-1:0]                 data_in [DEPTH],
    input  logic                             pop,
    output logic                             full,
    output logic                             empty,
    output logic [$clog2(NUM_SEQ+1)-1:0]     count,
    output logic                             overflow,
    output logic [DEPTH-1:0][WIDTH-1:0]      rd_seq
);

    localparam int PTR_W = $clog2(NUM_SEQ);
    localparam int CNT_W = $clog2(NUM_SEQ + 1);
    localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(NUM_SEQ - 1);

    logic [DEPTH-1:0][WIDTH-1:0] mem [NUM_SEQ];
    logic [PTR_W-1:0]            wr_ptr;
    logic [PTR_W-1:0]            rd_ptr;
    logic [PTR_W-1:0]            nxt_ptr;
    logic                        push;
    logic                        pop_ok;

    assign full    = (count == CNT_W'(NUM_SEQ));
    assign empty   = (count == '0);
    // full is the pre-edge value, so a slot freed on this edge does not admit a write
    assign push    = push_req && !full;
    assign pop_ok  = pop && !empty;
    assign nxt_ptr = (rd_ptr == LAST_SLOT) ? '0 : rd_ptr + 1'b1;
    assign rd_seq  = mem[pop_ok ? nxt_ptr : rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= (wr_ptr == LAST_SLOT) ? '0 : wr_ptr + 1'b1;
            if (pop_ok)
                rd_ptr <= nxt_ptr;
            case ({push, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            if (push_req && full)
                overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            for (int d = 0; d < DEPTH; d++)
                mem[wr_ptr][d] <= data_in[d];
        end
    end

endmodule

// File: rtl/tx_frame_serializer.sv
// Buffers whole DEPTH x WIDTH sequences and streams them out one byte at a
// time with a valid/ready handshake, optionally framed by a header byte and
// followed by an XOR checksum byte.
//   clk, rst_n  - clock, async active-low reset
//   valid_in    - sequence offered on array_in
//   array_in    - DEPTH x WIDTH sequence data
//   full, empty - store full / store empty
//   count       - stored sequences (including the one being sent)
//   overflow    - sticky dropped-write flag
//   byte_out    - registered byte presented downstream
//   valid_out   - byte_out is valid
//   ready_out   - downstream accepts byte_out this cycle
module tx_frame_serializer
    import tx_pkg::*;
#(
    parameter int    WIDTH        = 32,
    parameter int    DEPTH        = 8,
    parameter int    NUM_SEQ      = 10,
    parameter int    LSB_FIRST    = 1,
    parameter int    ELEM_DESCEND = 1,
    parameter int    HDR_EN       = 0,
    parameter int    CSUM_EN      = 0,
    parameter byte_t HDR_BYTE     = 8'hA5
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         valid_in,
    input  logic [WIDTH-1:0]             array_in [DEPTH],
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(NUM_SEQ+1)-1:0] count,
    output logic                         overflow,
    output logic [7:0]                   byte_out,
    output logic                         valid_out,
    input  logic                         ready_out
);

    localparam int CNT_W = $clog2(NUM_SEQ + 1);
    localparam int BPE   = bytes_per_elem(WIDTH);
    localparam int EW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int BW    = (BPE > 1) ? $clog2(BPE) : 1;
    localparam logic [EW-1:0] LAST_ELEM = EW'(DEPTH - 1);
    localparam logic [BW-1:0] LAST_BYTE = BW'(BPE - 1);
    localparam state_t FIRST_ST = (HDR_EN != 0) ? ST_HDR : ST_DATA;

    state_t                      state;
    state_t                      state_nxt;
    logic [DEPTH-1:0][WIDTH-1:0] rd_seq;
    logic                        pop;
    logic                        xfer;
    logic                        last_data;
    logic                        more;
    logic [EW-1:0]               elem_idx, elem_nxt, adv_e;
    logic [BW-1:0]               byte_idx, bidx_nxt, adv_b;
    byte_t                       csum, csum_nxt;
    byte_t                       byte_nxt;
    logic                        valid_nxt;
    logic                        start;

    tx_seq_fifo #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .NUM_SEQ (NUM_SEQ)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_req (valid_in),
        .data_in  (array_in),
        .pop      (pop),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow),
        .rd_seq   (rd_seq)
    );

    // send_tbl[e][b] is the b-th byte sent of the e-th element sent, so the
    // byte/element order parameters reduce to wiring here.
    byte_t send_tbl [DEPTH][BPE];

    for (genvar e = 0; e < DEPTH; e++) begin : g_elem
        for (genvar b = 0; b < BPE; b++) begin : g_byte
            localparam int EI   = (ELEM_DESCEND != 0) ? DEPTH - 1 - e : e;
            localparam int LANE = (LSB_FIRST != 0) ? b : BPE - 1 - b;
            assign send_tbl[e][b] = rd_seq[EI][LANE*8 +: 8];
        end
    end

    assign xfer      = valid_out && ready_out;
    assign last_data = (elem_idx == LAST_ELEM) && (byte_idx == LAST_BYTE);
    // count still includes the sequence finishing now, so >1 means another is queued
    assign more      = (count > CNT_W'(1));
    // The final byte is the checksum when enabled, otherwise the last data byte.
    assign pop       = xfer && (((state == ST_DATA) && last_data && (CSUM_EN == 0)) ||
                                (state == ST_CSUM));

    always_comb begin
        if (byte_idx == LAST_BYTE) begin
            adv_b = '0;
            adv_e = elem_idx + 1'b1;
        end else begin
            adv_b = byte_idx + 1'b1;
            adv_e = elem_idx;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (!empty) state_nxt = FIRST_ST;
            ST_HDR:  if (xfer)   state_nxt = ST_DATA;
            ST_DATA: begin
                if (xfer && last_data) begin
                    if (CSUM_EN != 0) state_nxt = ST_CSUM;
                    else              state_nxt = more ? FIRST_ST : ST_IDLE;
                end
            end
            ST_CSUM: if (xfer)   state_nxt = more ? FIRST_ST : ST_IDLE;
            default:             state_nxt = ST_IDLE;
        endcase
    end

    // Output / datapath next values. byte_out always holds the byte being
    // presented, so the checksum accumulates as each data byte is loaded.
    always_comb begin
        byte_nxt  = byte_out;
        valid_nxt = valid_out;
        elem_nxt  = elem_idx;
        bidx_nxt  = byte_idx;
        csum_nxt  = csum;
        start     = 1'b0;
        case (state)
            ST_IDLE: if (!empty) start = 1'b1;
            ST_HDR: begin
                if (xfer) begin
                    elem_nxt = '0;
                    bidx_nxt = '0;
                    byte_nxt = send_tbl[EW'(0)][BW'(0)];
                    csum_nxt = send_tbl[EW'(0)][BW'(0)];
                end
            end
            ST_DATA: begin
                if (xfer) begin
                    if (!last_data) begin
                        elem_nxt = adv_e;
                        bidx_nxt = adv_b;
                        byte_nxt = send_tbl[adv_e][adv_b];
                        csum_nxt = csum ^ send_tbl[adv_e][adv_b];
                    end else if (CSUM_EN != 0) begin
                        byte_nxt = csum;
                    end else begin
                        start = more;
                    end
                end
            end
            ST_CSUM: if (xfer) start = more;
            default: ;
        endcase
        if (pop && !more) begin
            valid_nxt = 1'b0;
            byte_nxt  = '0;
        end
        // While pop is high the read port already shows the next slot, so
        // send_tbl[0][0] is the first byte of whichever sequence starts now.
        if (start) begin
            valid_nxt = 1'b1;
            elem_nxt  = '0;
            bidx_nxt  = '0;
            if (HDR_EN != 0) begin
                byte_nxt = HDR_BYTE;
                csum_nxt = '0;
            end else begin
                byte_nxt = send_tbl[EW'(0)][BW'(0)];
                csum_nxt = send_tbl[EW'(0)][BW'(0)];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_out  <= '0;
            valid_out <= 1'b0;
            elem_idx  <= '0;
            byte_idx  <= '0;
            csum      <= '0;
        end else begin
            byte_out  <= byte_nxt;
            valid_out <= valid_nxt;
            elem_idx  <= elem_nxt;
            byte_idx  <= bidx_nxt;
            csum      <= csum_nxt;
        end
    end

endmodule

// File: tb/tb_tx_frame_serializer.sv
// Directed bench: instance A uses default parameters, instance B uses
// MSB-first / ascending elements with header and checksum.
module tb_tx_frame_serializer;

    localparam int WIDTH   = 32;
    localparam int DEPTH   = 8;
    localparam int NUM_SEQ = 10;
    localparam int NB      = DEPTH * WIDTH / 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        a_valid_in, a_ready, a_full, a_empty, a_overflow, a_valid_out;
    logic [31:0] a_array [DEPTH];
    logic [3:0]  a_count;
    logic [7:0]  a_byte;

    logic        b_valid_in, b_ready, b_full, b_empty, b_overflow, b_valid_out;
    logic [31:0] b_array [DEPTH];
    logic [3:0]  b_count;
    logic [7:0]  b_byte;

    int n_checks = 0;
    int n_fail   = 0;

    tx_frame_serializer #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_SEQ(NUM_SEQ)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n), .valid_in(a_valid_in), .array_in(a_array),
        .full(a_full), .empty(a_empty), .count(a_count), .overflow(a_overflow),
        .byte_out(a_byte), .valid_out(a_valid_out), .ready_out(a_ready)
    );

    tx_frame_serializer #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_SEQ(NUM_SEQ),
        .LSB_FIRST(0), .ELEM_DESCEND(0), .HDR_EN(1), .CSUM_EN(1)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n), .valid_in(b_valid_in), .array_in(b_array),
        .full(b_full), .empty(b_empty), .count(b_count), .overflow(b_overflow),
        .byte_out(b_byte), .valid_out(b_valid_out), .ready_out(b_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Element k of sequence s; s=0 gives k*32'h01010101 + k.
    function automatic logic [31:0] seq_word(input int s, input int k);
        return 32'(k) * 32'h01010101 + 32'(k) + 32'(s) * 32'h10203040;
    endfunction

    // Default order: element DEPTH-1 first, byte 0 of each element first.
    function automatic logic [7:0] exp_a(input int s, input int idx);
        logic [31:0] w;
        w = seq_word(s, DEPTH - 1 - idx / 4);
        return w[8*(idx%4) +: 8];
    endfunction

    task automatic load_a(input int s);
        for (int k = 0; k < DEPTH; k++) a_array[k] = seq_word(s, k);
    endtask

    // Checks one whole sequence on A. stall drops ready for two cycles
    // mid-sequence; wr_s >= 0 writes that sequence on the final-byte edge.
    task automatic drain_a(input int s, input bit stall, input int wr_s);
        int idx;
        int cyc;
        idx = 0;
        cyc = 0;
        while (idx < NB && cyc < 100) begin
            check($sformatf("a_valid s%0d i%0d", s, idx), a_valid_out, 1);
            check($sformatf("a_byte s%0d i%0d", s, idx), a_byte, exp_a(s, idx));
            a_ready = !(stall && (cyc == 11 || cyc == 12));
            if (wr_s >= 0 && a_ready && idx == NB - 1) begin
                load_a(wr_s);
                a_valid_in = 1'b1;
            end
            @(negedge clk);
            a_valid_in = 1'b0;
            if (a_ready) idx++;
            cyc++;
        end
        if (idx < NB) begin
            n_checks++;
            n_fail++;
            $error("FAIL a_drain_timeout s%0d: sent %0d expected %0d", s, idx, NB);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] eb;
        a_valid_in = 1'b0;
        a_ready    = 1'b0;
        b_valid_in = 1'b0;
        b_ready    = 1'b0;
        load_a(0);
        for (int k = 0; k < DEPTH; k++) b_array[k] = 32'h11223344;

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst a_full", a_full, 0);
        check("rst a_empty", a_empty, 1);
        check("rst a_count", a_count, 0);
        check("rst a_overflow", a_overflow, 0);
        check("rst a_valid", a_valid_out, 0);
        check("rst a_byte", a_byte, 0);
        check("rst b_full", b_full, 0);
        check("rst b_empty", b_empty, 1);
        check("rst b_count", b_count, 0);
        check("rst b_overflow", b_overflow, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single default-order sequence, 32 consecutive bytes
        a_valid_in = 1'b1;
        a_ready    = 1'b1;
        @(negedge clk);
        a_valid_in = 1'b0;
        check("a_latency_valid", a_valid_out, 0);
        check("a_latency_count", a_count, 1);
        @(negedge clk);
        drain_a(0, 1'b0, -1);
        check("a_done_valid", a_valid_out, 0);
        check("a_done_empty", a_empty, 1);

        // Header + MSB-first ascending + checksum
        b_valid_in = 1'b1;
        b_ready    = 1'b1;
        @(negedge clk);
        b_valid_in = 1'b0;
        check("b_latency_valid", b_valid_out, 0);
        @(negedge clk);
        for (int i = 0; i < NB + 2; i++) begin
            if (i == 0)           eb = 8'hA5;
            else if (i == NB + 1) eb = 8'h00;
            else begin
                case ((i - 1) % 4)
                    0:       eb = 8'h11;
                    1:       eb = 8'h22;
                    2:       eb = 8'h33;
                    default: eb = 8'h44;
                endcase
            end
            check($sformatf("b_valid i%0d", i), b_valid_out, 1);
            check($sformatf("b_byte i%0d", i), b_byte, eb);
            @(negedge clk);
        end
        check("b_done_valid", b_valid_out, 0);
        check("b_done_empty", b_empty, 1);

        // Eleven writes with the link stalled
        a_ready = 1'b0;
        for (int w = 0; w < 11; w++) begin
            load_a(w + 1);
            a_valid_in = 1'b1;
            @(negedge clk);
            if (w == 9) begin
                check("fill10 full", a_full, 1);
                check("fill10 count", a_count, 10);
                check("fill10 overflow", a_overflow, 0);
            end
        end
        a_valid_in = 1'b0;
        check("fill11 overflow", a_overflow, 1);
        check("fill11 count", a_count, 10);
        check("fill11 full", a_full, 1);
        check("stalled valid", a_valid_out, 1);
        check("stalled byte", a_byte, exp_a(1, 0));
        @(negedge clk);
        check("stalled byte hold", a_byte, exp_a(1, 0));

        // Drain: first with a mid-sequence stall, then back-to-back
        drain_a(1, 1'b1, -1);
        for (int s = 2; s <= 7; s++) drain_a(s, 1'b0, -1);
        check("count before same-edge", a_count, 3);
        drain_a(8, 1'b0, 12);
        check("count after same-edge", a_count, 3);
        drain_a(9, 1'b0, -1);
        drain_a(10, 1'b0, -1);
        drain_a(12, 1'b0, -1);
        check("drained valid", a_valid_out, 0);
        check("drained empty", a_empty, 1);
        check("overflow sticky", a_overflow, 1);

        // Reset in the middle of a sequence with another queued
        load_a(13);
        a_valid_in = 1'b1;
        a_ready    = 1'b1;
        @(negedge clk);
        load_a(15);
        @(negedge clk);
        a_valid_in = 1'b0;
        check("pre-rst byte0", a_byte, exp_a(13, 0));
        repeat (2) @(negedge clk);
        check("pre-rst byte2", a_byte, exp_a(13, 2));
        check("pre-rst count", a_count, 2);
        #2 rst_n = 1'b0;
        #1;
        check("mid-rst valid", a_valid_out, 0);
        check("mid-rst count", a_count, 0);
        check("mid-rst empty", a_empty, 1);
        check("mid-rst full", a_full, 0);
        check("mid-rst overflow", a_overflow, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        load_a(14);
        a_valid_in = 1'b1;
        @(negedge clk);
        a_valid_in = 1'b0;
        check("post-rst count", a_count, 1);
        @(negedge clk);
        drain_a(14, 1'b0, -1);
        check("post-rst empty", a_empty, 1);
        check("post-rst valid", a_valid_out, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
